cmp_serial_sequencer: RTL and testbench

- Compares two WIDTH-bit unsigned operands serially, one 2-bit slice per cycle, MSB slice first.
- Reuses a single 2-bit slice comparator, either an instance of comparator_2bit or equivalent logic.
- Sits between a requesting datapath and the shared compare resource.
- Uses a start/busy/done handshake and drives the full eq/neq/lt/lte/gt/gte flag set.

---
 rtl/cmp_serial_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_cmp_serial_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_serial_sequencer.sv
// ----------------------------------------------------------------------------
// cmp_serial_sequencer
//
// Serial magnitude comparator for two WIDTH-bit unsigned operands. One 2-bit
// slice is compared per cycle, starting from the most significant slice. The
// first differing slice decides the result, and later slices cannot override
// it. Uses a start/busy/done handshake.
//
// Optional build macro: CMP_SERIAL_EARLY_EXIT_EN
//   Defined   : RUN ends as soon as the first differing slice is found.
//   Undefined : fixed latency of NSLICE+1 cycles from start to done.
//   The result flags are identical in both builds.
//
// Ports:
//   clk    in   clock; all state updates on the rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request; sampled only in IDLE
//   a, b   in   WIDTH-bit operands, captured when start is accepted
//   busy   out  high from the cycle after an accepted start through DONE
//   done   out  single-cycle pulse; flags are valid from this cycle on
//   eq/neq/lt/lte/gt/gte out  registered result flags, held until the next
//                             DONE or reset
// ----------------------------------------------------------------------------
module cmp_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             neq,
  output logic             lt,
  output logic             lte,
  output logic             gt,
  output logic             gte
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NSLICE - 1);
  localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DEC_EQ = 2'd0,
    DEC_LT = 2'd1,
    DEC_GT = 2'd2
  } dec_t;

  // 2-bit slice comparator shared by every slice position.
  function automatic dec_t cmp2(input logic [1:0] x, input logic [1:0] y);
    dec_t r;
    if (x > y) begin
      r = DEC_GT;
    end else if (x < y) begin
      r = DEC_LT;
    end else begin
      r = DEC_EQ;
    end
    return r;
  endfunction

  // Flag vector packing: {eq, neq, lt, lte, gt, gte}.
  function automatic logic [5:0] flags_of(input dec_t d);
    logic f_eq;
    logic f_lt;
    logic f_gt;
    f_eq = (d == DEC_EQ);
    f_lt = (d == DEC_LT);
    f_gt = (d == DEC_GT);
    return {f_eq, ~f_eq, f_lt, f_lt | f_eq, f_gt, f_gt | f_eq};
  endfunction

  state_t                      state_q, state_d;
  dec_t                        dec_q, dec_d;
  logic [WIDTH-1:0]            a_q, a_d;
  logic [WIDTH-1:0]            b_q, b_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [5:0]                  flags_q, flags_d;

  // Operands viewed as arrays of 2-bit slices so the current slice is a
  // simple indexed select.
  logic [NSLICE-1:0][1:0]      a_pk_s;
  logic [NSLICE-1:0][1:0]      b_pk_s;
  dec_t                        slice_dec_s;
  dec_t                        dec_next_s;
  logic                        finish_s;

  assign a_pk_s      = a_q;
  assign b_pk_s      = b_q;
  assign slice_dec_s = cmp2(a_pk_s[idx_q], b_pk_s[idx_q]);
  // Sticky decision: only an undecided compare takes the slice result.
  assign dec_next_s  = (dec_q == DEC_EQ) ? slice_dec_s : dec_q;

`ifdef CMP_SERIAL_EARLY_EXIT_EN
  assign finish_s = (idx_q == IDX_ZERO) || (dec_next_s != DEC_EQ);
`else
  assign finish_s = (idx_q == IDX_ZERO);
`endif

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_TOP;
          dec_d   = DEC_EQ;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        dec_d  = dec_next_s;
        busy_d = 1'b1;
        if (finish_s) begin
          // Flags load on entry to DONE so they are valid alongside done.
          done_d  = 1'b1;
          flags_d = flags_of(dec_next_s);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q - IDX_ONE;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any compare in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dec_q   <= DEC_EQ;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      idx_q   <= IDX_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= 6'b000000;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      flags_q <= flags_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = flags_q[5];
  assign neq  = flags_q[4];
  assign lt   = flags_q[3];
  assign lte  = flags_q[2];
  assign gt   = flags_q[1];
  assign gte  = flags_q[0];

endmodule

// File: tb/tb_cmp_serial_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cmp_serial_sequencer
//
// Directed bench for cmp_serial_sequencer at WIDTH=8. Inputs are driven and
// outputs sampled on the falling clock edge. Flag vectors are packed as
// {eq, neq, lt, lte, gt, gte}. Expected latencies follow the build macro
// CMP_SERIAL_EARLY_EXIT_EN.
// ----------------------------------------------------------------------------
module tb_cmp_serial_sequencer;

  localparam logic [5:0] F_EQ   = 6'b100101;
  localparam logic [5:0] F_GT   = 6'b010011;
  localparam logic [5:0] F_LT   = 6'b011100;
  localparam logic [5:0] F_NONE = 6'b000000;

`ifdef CMP_SERIAL_EARLY_EXIT_EN
  localparam int LAT_MSB  = 2;
  localparam int RST_CYC  = 1;
`else
  localparam int LAT_MSB  = 5;
  localparam int RST_CYC  = 2;
`endif
  localparam int LAT_FULL = 5;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       busy, done, eq, neq, lt, lte, gt, gte;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc;
  int n_done;
  logic [5:0] last_flags;

  cmp_serial_sequencer #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .neq   (neq),
    .lt    (lt),
    .lte   (lte),
    .gt    (gt),
    .gte   (gte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] flags_now();
    return {eq, neq, lt, lte, gt, gte};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full operation: start, scramble inputs, wait for done, check latency,
  // flags and the return to idle with flags held.
  task automatic op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                    input logic [5:0] exp_flags, input int exp_lat);
    @(negedge clk);
    start = 1'b1; a_i = av; b_i = bv;
    @(negedge clk);
    start = 1'b0; a_i = ~av; b_i = bv ^ 8'h5A;
    cyc = 1;
    chk({tag, "_busy_t1"}, {7'd0, busy}, 8'd1);
    chk({tag, "_flags_held_t1"}, {2'd0, flags_now()}, {2'd0, last_flags});
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_latency"}, 8'(cyc), 8'(exp_lat));
    chk({tag, "_busy_done"}, {7'd0, busy}, 8'd1);
    chk({tag, "_flags"}, {2'd0, flags_now()}, {2'd0, exp_flags});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {7'd0, done}, 8'd0);
    chk({tag, "_busy_fall"}, {7'd0, busy}, 8'd0);
    chk({tag, "_flags_hold"}, {2'd0, flags_now()}, {2'd0, exp_flags});
    last_flags = exp_flags;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_i = 8'h00; b_i = 8'h00;
    last_flags = F_NONE;
    #1;
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    chk("reset_flags", {2'd0, flags_now()}, {2'd0, F_NONE});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Equal operands: full latency, eq flags.
    op("eq_a5", 8'hA5, 8'hA5, F_EQ, LAT_FULL);

    // Asynchronous reset between clock edges clears everything at once.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_flags", {2'd0, flags_now()}, {2'd0, F_NONE});
    chk("async_rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    last_flags = F_NONE;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("post_rst_idle", 8'(n_done), 8'd0);

    // MSB slice decides greater-than.
    op("gt_80_7f", 8'h80, 8'h7F, F_GT, LAT_MSB);
    // LSB slice decides less-than; flags from previous op held until done.
    op("lt_12_13", 8'h12, 8'h13, F_LT, LAT_FULL);

    // Start during RUN/DONE is ignored; start in first IDLE after DONE is taken.
    @(negedge clk);
    start = 1'b1; a_i = 8'h40; b_i = 8'h30;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        start = 1'b1; a_i = 8'h00; b_i = 8'hFF;
      end
    end
    chk("ign_done", {7'd0, done}, 8'd1);
    chk("ign_latency", 8'(cyc), 8'(LAT_MSB));
    chk("ign_flags", {2'd0, flags_now()}, {2'd0, F_GT});
    start = 1'b1; a_i = 8'h03; b_i = 8'h03;
    @(negedge clk);
    chk("ign_single_done", {7'd0, done}, 8'd0);
    chk("ign_idle_busy", {7'd0, busy}, 8'd0);
    chk("ign_flags_hold", {2'd0, flags_now()}, {2'd0, F_GT});
    @(negedge clk);
    start = 1'b0; a_i = 8'hF0; b_i = 8'h0F;
    chk("reaccept_busy", {7'd0, busy}, 8'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reaccept_latency", 8'(cyc), 8'(LAT_FULL));
    chk("reaccept_flags", {2'd0, flags_now()}, {2'd0, F_EQ});
    last_flags = F_EQ;

    // Reset during an operation: no done, outputs cleared, then recovery.
    @(negedge clk);
    start = 1'b1; a_i = 8'hFF; b_i = 8'h00;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < RST_CYC) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrun_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", {7'd0, busy}, 8'd0);
    chk("midrun_rst_done", {7'd0, done}, 8'd0);
    chk("midrun_rst_flags", {2'd0, flags_now()}, {2'd0, F_NONE});
    @(negedge clk);
    rst = 1'b0;
    last_flags = F_NONE;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrun_no_done", 8'(n_done), 8'd0);
    op("lt_01_02", 8'h01, 8'h02, F_LT, LAT_FULL);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
